// File: rtl/line_rasterizer_if.sv
// Command and pixel-stream bundle for the Bresenham line rasterizer.
// The master side issues line commands and sinks pixels; the slave side is the rasterizer.
interface line_rasterizer_if #(
    parameter int COORD_W = 10
);
    logic               start;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic               cmd_ready;
    logic               busy;
    logic               pix_valid;
    logic               pix_ready;
    logic [COORD_W-1:0] x_out;
    logic [COORD_W-1:0] y_out;
    logic               pix_last;
    logic               done;

    modport master (
        output start, x1, y1, x2, y2, pix_ready,
        input  cmd_ready, busy, pix_valid, x_out, y_out, pix_last, done
    );

    modport slave (
        input  start, x1, y1, x2, y2, pix_ready,
        output cmd_ready, busy, pix_valid, x_out, y_out, pix_last, done
    );
endinterface

// File: rtl/line_rasterizer.sv
// Eight-octant Bresenham line rasterizer: one command in, one pixel per transfer out,
// with pixel-stream backpressure. All outputs come from registers or the state decode.
module line_rasterizer #(
    parameter int COORD_W = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    line_rasterizer_if.slave     bus
);
    localparam int DW  = COORD_W + 1;  // dx / dy
    localparam int EW  = COORD_W + 2;  // err
    localparam int E2W = COORD_W + 3;  // 2*err

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [COORD_W-1:0]     x1_q, y1_q, x2_q, y2_q;
    logic [COORD_W-1:0]     x1_d, y1_d, x2_d, y2_d;
    logic [COORD_W-1:0]     x_q, y_q, x_d, y_d;
    logic signed [DW-1:0]   dx_q, dy_q, dx_d, dy_d;
    logic                   sx_neg_q, sy_neg_q, sx_neg_d, sy_neg_d;
    logic signed [EW-1:0]   err_q, err_d;

    // Setup arithmetic on the latched endpoints
    logic signed [DW-1:0]   xdiff, ydiff, adx, ndy;
    assign xdiff = $signed({1'b0, x2_q}) - $signed({1'b0, x1_q});
    assign ydiff = $signed({1'b0, y2_q}) - $signed({1'b0, y1_q});
    assign adx   = xdiff[DW-1] ? -xdiff : xdiff;
    assign ndy   = ydiff[DW-1] ? ydiff : -ydiff;

    // Step decision: both tests use the error value from before this step
    logic signed [E2W-1:0]  e2, dx_w, dy_w;
    logic signed [EW-1:0]   dx_e, dy_e, add_x, add_y;
    logic                   step_x, step_y, at_end;

    assign e2     = $signed({err_q, 1'b0});
    assign dx_w   = {{2{dx_q[DW-1]}}, dx_q};
    assign dy_w   = {{2{dy_q[DW-1]}}, dy_q};
    assign dx_e   = {dx_q[DW-1], dx_q};
    assign dy_e   = {dy_q[DW-1], dy_q};
    assign step_x = (e2 >= dy_w);
    assign step_y = (e2 <= dx_w);
    assign add_x  = step_x ? dy_e : {EW{1'b0}};
    assign add_y  = step_y ? dx_e : {EW{1'b0}};
    assign at_end = (x_q == x2_q) && (y_q == y2_q);

    always_comb begin
        state_d  = state_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        x2_d     = x2_q;
        y2_d     = y2_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x1_d    = bus.x1;
                    y1_d    = bus.y1;
                    x2_d    = bus.x2;
                    y2_d    = bus.y2;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                dx_d     = adx;
                dy_d     = ndy;
                sx_neg_d = xdiff[DW-1];
                sy_neg_d = ydiff[DW-1];
                err_d    = {adx[DW-1], adx} + {ndy[DW-1], ndy};
                x_d      = x1_q;
                y_d      = y1_q;
                state_d  = DRAW;
            end
            DRAW: begin
                if (bus.pix_ready) begin
                    if (at_end) begin
                        state_d = DONE;
                    end else begin
                        err_d = err_q + add_x + add_y;
                        if (step_x) x_d = sx_neg_q ? (x_q - ONE) : (x_q + ONE);
                        if (step_y) y_d = sy_neg_q ? (y_q - ONE) : (y_q + ONE);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            x1_q     <= '0;
            y1_q     <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            x2_q     <= x2_d;
            y2_q     <= y2_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.pix_valid = (state_q == DRAW);
    assign bus.pix_last  = (state_q == DRAW) && at_end;
    assign bus.done      = (state_q == DONE);
    assign bus.x_out     = x_q;
    assign bus.y_out     = y_q;
endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: octant lines, degenerate line, backpressure,
// full-range diagonal and mid-line reset, each against hand-computed pixel lists.
module tb_line_rasterizer;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    line_rasterizer_if #(.COORD_W(CW)) rif ();

    line_rasterizer #(.COORD_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (rif)
    );

    // Issues one command at a negedge; returns at the negedge after the accept edge
    // with the endpoint inputs scrambled.
    task automatic send_cmd(input int ax1, input int ay1, input int ax2, input int ay2);
        int t;
        t = 0;
        while (rif.cmd_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (rif.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", rif.cmd_ready);
        end
        rif.x1    = CW'(ax1);
        rif.y1    = CW'(ay1);
        rif.x2    = CW'(ax2);
        rif.y2    = CW'(ay2);
        rif.start = 1'b1;
        @(negedge clk);
        rif.start = 1'b0;
        rif.x1    = CW'($urandom);
        rif.y1    = CW'($urandom);
        rif.x2    = CW'($urandom);
        rif.y2    = CW'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rif.cmd_ready, rif.busy, rif.pix_valid, rif.pix_last, rif.done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: rdy/busy/val/last/done=%b required 10000",
                     {rif.cmd_ready, rif.busy, rif.pix_valid, rif.pix_last, rif.done});
        end
        n_checks++;
        if (rif.x_out !== '0 || rif.y_out !== '0) begin
            n_fail++;
            $display("FAIL reset_coords: got (%0d,%0d) required (0,0)", rif.x_out, rif.y_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lines();
        int cmd[2][4] = '{'{0, 0, 5, 2}, '{3, 5, 1, 0}};
        int ex[2][6]  = '{'{0, 1, 2, 3, 4, 5}, '{3, 3, 2, 2, 1, 1}};
        int ey[2][6]  = '{'{0, 0, 1, 1, 2, 2}, '{5, 4, 3, 2, 1, 0}};
        int n;
        int cyc;
        bit fin;
        for (int l = 0; l < 2; l++) begin
            n = 0; cyc = 0; fin = 1'b0;
            rif.pix_ready = 1'b1;
            send_cmd(cmd[l][0], cmd[l][1], cmd[l][2], cmd[l][3]);
            n_checks++;
            if ({rif.busy, rif.cmd_ready, rif.pix_valid} !== 3'b100) begin
                n_fail++;
                $display("FAIL setup_state line%0d: busy/rdy/val=%b required 100", l,
                         {rif.busy, rif.cmd_ready, rif.pix_valid});
            end
            @(negedge clk);
            n_checks++;
            if (rif.pix_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL first_valid line%0d: pix_valid=%b required 1", l, rif.pix_valid);
            end
            while (!fin && cyc < 50) begin
                if (rif.pix_valid === 1'b1) begin
                    n_checks++;
                    if (n >= 6) begin
                        n_fail++;
                        $display("FAIL extra_pixel line%0d: got (%0d,%0d) required none", l, rif.x_out, rif.y_out);
                        fin = 1'b1;
                    end else if (rif.x_out !== CW'(ex[l][n]) || rif.y_out !== CW'(ey[l][n]) ||
                                 rif.pix_last !== (n == 5)) begin
                        n_fail++;
                        $display("FAIL pixel line%0d #%0d: got (%0d,%0d,last=%b) required (%0d,%0d,last=%b)",
                                 l, n, rif.x_out, rif.y_out, rif.pix_last, ex[l][n], ey[l][n], (n == 5));
                    end
                    if (rif.pix_last === 1'b1) fin = 1'b1;
                    n++;
                end
                @(negedge clk);
                cyc++;
            end
            n_checks++;
            if (n != 6) begin
                n_fail++;
                $display("FAIL pixel_count line%0d: got %0d required 6", l, n);
            end
            n_checks++;
            if ({rif.done, rif.pix_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL done_pulse line%0d: done/val=%b required 10", l, {rif.done, rif.pix_valid});
            end
            @(negedge clk);
            n_checks++;
            if ({rif.done, rif.cmd_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL idle_return line%0d: done/rdy=%b required 01", l, {rif.done, rif.cmd_ready});
            end
        end
    endtask

    task automatic test_degenerate();
        int bad;
        rif.pix_ready = 1'b1;
        send_cmd(7, 7, 7, 7);
        // start while busy must not be queued
        rif.start = 1'b1;
        rif.x1 = CW'(100); rif.y1 = CW'(100); rif.x2 = CW'(200); rif.y2 = CW'(300);
        @(negedge clk);
        rif.start = 1'b0;
        n_checks++;
        if ({rif.pix_valid, rif.pix_last} !== 2'b11 || rif.x_out !== CW'(7) || rif.y_out !== CW'(7)) begin
            n_fail++;
            $display("FAIL degen_pixel: got (%0d,%0d,val=%b,last=%b) required (7,7,val=1,last=1)",
                     rif.x_out, rif.y_out, rif.pix_valid, rif.pix_last);
        end
        @(negedge clk);
        n_checks++;
        if ({rif.done, rif.pix_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL degen_done: done/val=%b required 10", {rif.done, rif.pix_valid});
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rif.pix_valid !== 1'b0 || rif.busy !== 1'b0 || rif.cmd_ready !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ignored_start: %0d busy/valid cycles after degenerate line, required 0", bad);
        end
    endtask

    task automatic test_backpressure();
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int n, k;
        bit fin, stalled;
        logic [CW-1:0] hx, hy;
        logic hl;
        n = 0; k = 0; fin = 1'b0; stalled = 1'b0;
        hx = '0; hy = '0; hl = 1'b0;
        rif.pix_ready = 1'b0;
        send_cmd(0, 0, 4, 0);
        @(negedge clk);
        while (!fin && k < 40) begin
            rif.pix_ready = pat[k % 4];
            if (stalled) begin
                n_checks++;
                if (rif.pix_valid !== 1'b1 || rif.x_out !== hx || rif.y_out !== hy || rif.pix_last !== hl) begin
                    n_fail++;
                    $display("FAIL stall_hold k=%0d: got (%0d,%0d,val=%b,last=%b) required (%0d,%0d,val=1,last=%b)",
                             k, rif.x_out, rif.y_out, rif.pix_valid, rif.pix_last, hx, hy, hl);
                end
            end
            stalled = 1'b0;
            if (rif.pix_valid === 1'b1 && rif.pix_ready === 1'b1) begin
                n_checks++;
                if (rif.x_out !== CW'(n) || rif.y_out !== '0 || rif.pix_last !== (n == 4)) begin
                    n_fail++;
                    $display("FAIL bp_pixel #%0d: got (%0d,%0d,last=%b) required (%0d,0,last=%b)",
                             n, rif.x_out, rif.y_out, rif.pix_last, n, (n == 4));
                end
                if (rif.pix_last === 1'b1) fin = 1'b1;
                n++;
            end else if (rif.pix_valid === 1'b1) begin
                stalled = 1'b1;
                hx = rif.x_out; hy = rif.y_out; hl = rif.pix_last;
            end
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL bp_count: got %0d transfers required 5", n);
        end
        n_checks++;
        if (rif.done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: done=%b required 1", rif.done);
        end
        @(negedge clk);
    endtask

    task automatic test_extremes();
        int n, bad, cyc;
        logic [CW-1:0] fx, fy, lx, ly;
        n = 0; bad = 0; cyc = 0;
        fx = '0; fy = '0; lx = '0; ly = '0;
        rif.pix_ready = 1'b1;
        send_cmd(1023, 0, 0, 1023);
        @(negedge clk);
        while (rif.pix_valid === 1'b1 && cyc < 1100) begin
            if (n == 0) begin fx = rif.x_out; fy = rif.y_out; end
            if (int'(rif.x_out) + int'(rif.y_out) != 1023) bad++;
            lx = rif.x_out; ly = rif.y_out;
            n++;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (n != 1024) begin
            n_fail++;
            $display("FAIL ext_count: got %0d pixels required 1024", n);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ext_diagonal: %0d pixels off x+y==1023, required 0", bad);
        end
        n_checks++;
        if (fx !== CW'(1023) || fy !== '0 || lx !== '0 || ly !== CW'(1023)) begin
            n_fail++;
            $display("FAIL ext_ends: got first (%0d,%0d) last (%0d,%0d) required (1023,0) and (0,1023)",
                     fx, fy, lx, ly);
        end
        n_checks++;
        if (rif.done !== 1'b1) begin
            n_fail++;
            $display("FAIL ext_done: done=%b required 1", rif.done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midline();
        int ex[3] = '{3, 4, 5};
        int ey[3] = '{1, 2, 2};
        int n, cyc, dones;
        bit fin;
        rif.pix_ready = 1'b1;
        send_cmd(0, 0, 9, 9);
        repeat (3) @(negedge clk);
        n_checks++;
        if (rif.pix_valid !== 1'b1 || rif.x_out !== CW'(2) || rif.y_out !== CW'(2)) begin
            n_fail++;
            $display("FAIL third_pixel: got (%0d,%0d,val=%b) required (2,2,val=1)", rif.x_out, rif.y_out, rif.pix_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({rif.pix_valid, rif.cmd_ready, rif.busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL async_reset: val/rdy/busy=%b required 010", {rif.pix_valid, rif.cmd_ready, rif.busy});
        end
        dones = 0;
        @(negedge clk);
        if (rif.done !== 1'b0) dones++;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rif.done !== 1'b0) dones++;
        end
        n_checks++;
        if (dones != 0 || rif.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_done: %0d done cycles, cmd_ready=%b required 0 and 1", dones, rif.cmd_ready);
        end
        send_cmd(3, 1, 5, 2);
        @(negedge clk);
        n = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 20) begin
            if (rif.pix_valid === 1'b1) begin
                n_checks++;
                if (n >= 3) begin
                    n_fail++;
                    $display("FAIL post_reset_extra: got (%0d,%0d) required none", rif.x_out, rif.y_out);
                    fin = 1'b1;
                end else if (rif.x_out !== CW'(ex[n]) || rif.y_out !== CW'(ey[n]) || rif.pix_last !== (n == 2)) begin
                    n_fail++;
                    $display("FAIL post_reset_pixel #%0d: got (%0d,%0d,last=%b) required (%0d,%0d,last=%b)",
                             n, rif.x_out, rif.y_out, rif.pix_last, ex[n], ey[n], (n == 2));
                end
                if (rif.pix_last === 1'b1) fin = 1'b1;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (n != 3 || rif.done !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_count: got %0d pixels done=%b required 3 and 1", n, rif.done);
        end
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        rif.start     = 1'b0;
        rif.pix_ready = 1'b0;
        rif.x1        = '0;
        rif.y1        = '0;
        rif.x2        = '0;
        rif.y2        = '0;
        test_reset();
        test_lines();
        test_degenerate();
        test_backpressure();
        test_extremes();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
